// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit register; captures even/odd parity of the byte on accept.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    input  logic                  load,
    output logic                  par_bit
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            par_bit <= 1'b0;
        end else if (load) begin
            par_bit <= (^data) ^ (par_typ == PAR_ODD);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop and drives the line.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e state_q, state_d;
    logic      par_en_q;
    logic      par_bit;
    logic      accept;
    logic      tx_d;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .clk     (clk),
        .reset   (reset),
        .data    (P_Data),
        .par_typ (PAR_TYP),
        .load    (accept),
        .par_bit (par_bit)
    );

    // Next state, serializer enable and line value for the current state.
    always_comb begin
        state_d = state_q;
        ser_en  = 1'b0;
        accept  = 1'b0;
        tx_d    = LINE_IDLE;
        unique case (state_q)
            IDLE: begin
                tx_d = LINE_IDLE;
                if (Data_Valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx_d    = START_BIT;
                state_d = DATA;
            end
            DATA: begin
                tx_d   = ser_data;
                ser_en = 1'b1;
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_d    = par_bit;
                state_d = STOP;
            end
            STOP: begin
                tx_d = STOP_BIT;
                // Back-to-back accept skips IDLE so no idle bit separates frames.
                if (Data_Valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            TX_OUT   <= LINE_IDLE;
            par_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            if (accept) begin
                par_en_q <= PAR_EN;
            end
        end
    end

    assign Busy = (state_q != IDLE);

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmitter. It accepts a parallel byte with a valid strobe and drives the shift enable of the downstream bit serializer. It builds the line frame: start bit, LSB-first data bits from the serializer, optional even/odd parity, and stop bit. It also owns the TX line register and the Busy flag reported to the host side.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; width of P_Data.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-low reset.
P_Data  in  DATA_WIDTH  parallel byte to transmit; sampled only on accept.
Data_Valid  in  1  request strobe; an accept occurs when it is high in IDLE, or in STOP (back-to-back).
PAR_EN  in  1  1 = insert a parity bit; sampled on accept.
PAR_TYP  in  1  0 = even parity, 1 = odd parity; sampled on accept.
ser_done  in  1  serializer flag, high in the cycle its last data bit is on ser_data.
ser_data  in  1  current serial data bit from the serializer.
ser_en  out  1  serializer shift enable.
TX_OUT  out  1  UART line; idles high.
Busy  out  1  high while a frame is in progress.

Behaviour:
- Reset is synchronous, active-low. When reset=0 at a clock edge:
  - state becomes IDLE; TX_OUT=1, Busy=0, ser_en=0.
  - Latched data, parity bit and config are cleared.
  - Reset mid-frame aborts the frame; the line returns high on the next edge.
- States: IDLE, START, DATA, PARITY, STOP, held in a registered state variable.
- IDLE: if Data_Valid=1, accept: latch P_Data, PAR_EN and PAR_TYP, compute the parity bit, and go to START. Otherwise stay in IDLE.
- START: one cycle, then go to DATA.
- DATA: ser_en=1 for every cycle in this state (combinational from state), and 0 in all other states.
  - Stay in DATA while ser_done=0.
  - When ser_done=1, go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY: one cycle, then go to STOP.
- STOP: one cycle.
  - If Data_Valid=1 in this cycle, it is an accept: latch the new byte and config and go directly to START, with no idle bit between frames.
  - Otherwise go to IDLE.
- Data_Valid in START, DATA or PARITY is ignored. There is no queue; the host must watch Busy.
- Serializer contract:
  - While ser_en=1, the serializer presents one bit per cycle, LSB first, on ser_data.
  - The first bit appears in the first DATA cycle; ser_done accompanies bit DATA_WIDTH-1.
  - The serializer is loaded by the same Data_Valid accept.
- Parity is computed from the latched byte:
  - even: par_bit = XOR-reduce(data).
  - odd: par_bit = NOT XOR-reduce(data).
- TX_OUT is registered: TX_OUT <= mux(state), so the line lags the state by exactly one cycle.
  - IDLE -> 1; START -> 0; DATA -> ser_data; PARITY -> par_bit; STOP -> 1.
- Busy = (state != IDLE), taken from the state register, so it is glitch-free.
- Frame length on the line: 1 + DATA_WIDTH + PAR_EN + 1 cycles, i.e. 11 cycles (8 data bits, parity on) or 10 cycles (parity off).
- Latency: accept at edge T gives state START after T; the start bit (TX_OUT=0) is visible after edge T+1.
- A ser_done that arrives early is taken as given: DATA exits on it without an internal bit-count check. A missing ser_done holds DATA indefinitely; a serializer-fault watchdog is out of scope.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - PAR_EVEN=0 and PAR_ODD=1.
  - LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - Default DATA_WIDTH.
- One sub-module, uart_parity_calc:
  - Inputs: DATA_WIDTH data, PAR_TYP, enable-load.
  - Output: registered par_bit, updated on accept only.
- The FSM and the output mux stay in uart_tx_ctrl.

Test Plan:
1. Reset, then P_Data=8'hA5, PAR_EN=1, PAR_TYP=0, with a 1-cycle Data_Valid in IDLE, using the bench serializer model -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop). Busy is high for exactly 11 cycles, and ser_en is high for exactly 8 cycles.
2. P_Data=8'h01 with PAR_EN=1: with PAR_TYP=1 -> parity bit 0; with PAR_TYP=0 -> parity bit 1.
3. PAR_EN=0, P_Data=8'hFF -> 10-cycle frame 0,1×8,1. The state never enters PARITY; Busy drops the cycle after STOP.
4. Data_Valid pulsed during DATA with P_Data=8'h3C -> ignored, and the current frame bits are unchanged. Data_Valid held high through STOP with 8'h3C -> the next start bit immediately follows the stop bit, and Busy never drops.
5. reset=0 asserted in DATA at bit 4 -> on the next edge TX_OUT=1, Busy=0, ser_en=0, state IDLE. A new accept afterwards yields a complete correct frame.
6. Data_Valid held low with the line idle for 20 cycles -> TX_OUT=1, Busy=0, ser_en=0 throughout.
